// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle PUSH/POP/SAVE_ALL/RESTORE_ALL sequencer between register bank and data memory
module stack_sequencer #(
  parameter logic [11:0] STACK_TOP   = 12'h000,
  parameter logic [11:0] STACK_LIMIT = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_reg,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [3:0]  rb_read_sel,
  input  logic [15:0] rb_read_data,
  output logic        rb_write_en,
  output logic [3:0]  rb_write_sel,
  output logic [15:0] rb_write_data,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  input  logic [15:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD_SP, XFER, WAIT_RD, WB_SP, FINISH} state_t;
  localparam logic [11:0] CAP = STACK_TOP - STACK_LIMIT;
  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d, err_q, err_d;
  logic [3:0]  reg_q, reg_d;
  logic [11:0] sp_q, sp_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] used;
  logic [2:0]  cur;
  logic        multi, is_push, last, ovf, unf, bad_reg;
  assign multi   = op_q[1];
  assign is_push = ~op_q[0];
  assign cur     = multi ? (op_q[0] ? ~cnt_q : cnt_q) : reg_q[2:0];
  assign last    = ~multi | (cnt_q == 3'd7);
  // occupancy is derived from the SP being read this cycle, not the stale sp_q
  assign used    = STACK_TOP - rb_read_data[11:0];
  assign bad_reg = ~multi & reg_q[3];
  assign ovf     = multi ? ({1'b0, used} + 13'd8 > {1'b0, CAP}) : (used == CAP);
  assign unf     = multi ? (used < 12'd8) : (used == 12'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      err_q   <= '0;
      reg_q   <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      reg_q   <= reg_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    err_d         = err_q;
    reg_d         = reg_q;
    sp_d          = sp_q;
    cnt_d         = cnt_q;
    cmd_ready     = state_q == IDLE;
    busy          = state_q != IDLE;
    done          = state_q == FINISH;
    err           = state_q == FINISH ? err_q : 2'd0;
    rb_read_sel   = '0;
    rb_write_en   = 1'b0;
    rb_write_sel  = '0;
    rb_write_data = '0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    mem_re        = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        reg_d   = cmd_reg;
        cnt_d   = '0;
        err_d   = '0;
        state_d = LOAD_SP;
      end
      LOAD_SP: begin
        rb_read_sel = 4'd8;
        sp_d        = rb_read_data[11:0];
        err_d       = bad_reg ? 2'd3 : (is_push & ovf) ? 2'd1 : (~is_push & unf) ? 2'd2 : 2'd0;
        state_d     = err_d != 2'd0 ? FINISH : XFER;
      end
      XFER: if (is_push) begin
        rb_read_sel = {1'b0, cur};
        mem_we      = 1'b1;
        mem_addr    = sp_q - 12'd1;
        mem_wdata   = rb_read_data;
        sp_d        = sp_q - 12'd1;
        cnt_d       = cnt_q + 3'd1;
        state_d     = last ? WB_SP : XFER;
      end else begin
        mem_re   = 1'b1;
        mem_addr = sp_q;
        sp_d     = sp_q + 12'd1;
        state_d  = WAIT_RD;
      end
      WAIT_RD: begin
        rb_write_en   = 1'b1;
        rb_write_sel  = {1'b0, cur};
        rb_write_data = mem_rdata;
        cnt_d         = cnt_q + 3'd1;
        state_d       = last ? WB_SP : XFER;
      end
      WB_SP: begin
        rb_write_en   = 1'b1;
        rb_write_sel  = 4'd8;
        rb_write_data = {4'b0, sp_q};
        state_d       = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: table vectors, directed corner sequences and random commands against a stack model
module tb_stack_sequencer;
  localparam logic [11:0] TOP = 12'h000;
  localparam logic [11:0] LIM = 12'hF00;
  localparam logic [11:0] CAP = TOP - LIM;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        cmd_valid = 0, cmd_ready, busy, done, rb_write_en, mem_we, mem_re;
  logic [1:0]  cmd_op = 0, err;
  logic [3:0]  cmd_reg = 0, rb_read_sel, rb_write_sel;
  logic [15:0] rb_read_data, rb_write_data, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  stack_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .busy(busy), .done(done), .err(err), .rb_read_sel(rb_read_sel),
    .rb_read_data(rb_read_data), .rb_write_en(rb_write_en), .rb_write_sel(rb_write_sel),
    .rb_write_data(rb_write_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );
  // environment: register bank and memory, plus write counters
  logic [15:0] bank [16];
  logic [15:0] mem [4096];
  logic [15:0] pv [9];
  logic        poke = 0, clr = 0, cnt_clr = 0;
  int          rbw_n = 0, mw_n = 0;
  assign rb_read_data = bank[rb_read_sel];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 4096; i++) mem[i] <= '0;
    if (poke) for (int i = 0; i < 9; i++) bank[i] <= pv[i];
    else if (rb_write_en) bank[rb_write_sel] <= rb_write_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    rbw_n <= cnt_clr ? 0 : rbw_n + int'(rb_write_en);
    mw_n  <= cnt_clr ? 0 : mw_n + int'(mem_we);
  end
  // reference model: plain stack semantics over register and memory arrays
  logic [15:0] mr [9];
  logic [15:0] mm [4096];
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_cmd(input logic [1:0] op, input logic [3:0] r, output logic [1:0] e);
    logic [11:0] sp, used;
    sp = mr[8][11:0];
    used = TOP - sp;
    if (op < 2 && r > 7) e = 3;
    else if ((op == 0 && used == CAP) || (op == 2 && int'(used) + 8 > int'(CAP))) e = 1;
    else if ((op == 1 && used == 0) || (op == 3 && used < 8)) e = 2;
    else begin
      e = 0;
      case (op)
        2'd0: begin sp = sp - 1; mm[sp] = mr[r[2:0]]; end
        2'd1: begin mr[r[2:0]] = mm[sp]; sp = sp + 1; end
        2'd2: for (int i = 0; i < 8; i++) begin sp = sp - 1; mm[sp] = mr[i]; end
        default: for (int i = 7; i >= 0; i--) begin mr[i] = mm[sp]; sp = sp + 1; end
      endcase
      mr[8] = {4'h0, sp};
    end
  endtask
  function automatic int exp_lat(input logic [1:0] op, input logic [1:0] e);
    if (e != 0) return 2;
    case (op)
      2'd0: return 4;
      2'd1: return 5;
      2'd2: return 11;
      default: return 19;
    endcase
  endfunction
  task automatic poke_all();
    @(negedge clk);
    for (int i = 0; i < 9; i++) pv[i] = mr[i];
    poke = 1;
    @(negedge clk);
    poke = 0;
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] r, output logic [1:0] e, output int lat);
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_reg = r; cnt_clr = 1;
    @(posedge clk);
    #1 cmd_valid = 0; cnt_clr = 0; cmd_op = 2'($urandom); cmd_reg = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("we_re_exclusive", mem_we & mem_re, 0);
    end while (!done && lat < 40);
    e = err;
  endtask
  typedef struct {
    logic [1:0] op; logic [3:0] r; logic [11:0] sp;
    logic [1:0] e; int lat; logic [11:0] nsp; int rbw; int mw;
  } vec_t;
  vec_t tv [13];
  logic [1:0] e, me;
  int lat;
  logic [11:0] sp_pick [9];
  initial begin
    tv[0]  = '{2'd0, 4'd3,  12'h000, 2'd0, 4,  12'hFFF, 1, 1};
    tv[1]  = '{2'd1, 4'd1,  12'h000, 2'd2, 2,  12'h000, 0, 0};
    tv[2]  = '{2'd0, 4'd0,  12'hF00, 2'd1, 2,  12'hF00, 0, 0};
    tv[3]  = '{2'd2, 4'd0,  12'hF04, 2'd1, 2,  12'hF04, 0, 0};
    tv[4]  = '{2'd2, 4'd0,  12'hF08, 2'd0, 11, 12'hF00, 1, 8};
    tv[5]  = '{2'd0, 4'd8,  12'h000, 2'd3, 2,  12'h000, 0, 0};
    tv[6]  = '{2'd1, 4'd9,  12'h000, 2'd3, 2,  12'h000, 0, 0};
    tv[7]  = '{2'd3, 4'd0,  12'hFF9, 2'd2, 2,  12'hFF9, 0, 0};
    tv[8]  = '{2'd3, 4'd0,  12'hFF8, 2'd0, 19, 12'h000, 9, 0};
    tv[9]  = '{2'd1, 4'd2,  12'hFFF, 2'd0, 5,  12'h000, 2, 0};
    tv[10] = '{2'd0, 4'd7,  12'hF01, 2'd0, 4,  12'hF00, 1, 1};
    tv[11] = '{2'd2, 4'd5,  12'h000, 2'd0, 11, 12'hFF8, 1, 8};
    tv[12] = '{2'd1, 4'd15, 12'hF00, 2'd3, 2,  12'hF00, 0, 0};
    sp_pick = '{12'h000, 12'hFFF, 12'hFF8, 12'hFF9, 12'hF00, 12'hF01, 12'hF04, 12'hF08, 12'hF07};
    for (int i = 0; i < 4096; i++) mm[i] = '0;
    for (int i = 0; i < 9; i++) mr[i] = '0;
    clr = 1;
    repeat (2) @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, busy, done, err, rb_write_en, mem_we, mem_re, rb_read_sel,
                          rb_write_sel, rb_write_data, mem_addr, mem_wdata}, 60'h800_0000_0000_0000);
    rst = 0;
    // table vectors
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < 8; i++) mr[i] = 16'h1000 + 16'(k * 16 + i);
      mr[8] = {4'h0, tv[k].sp};
      poke_all();
      model_cmd(tv[k].op, tv[k].r, me);
      run_cmd(tv[k].op, tv[k].r, e, lat);
      chk($sformatf("tv%0d_err", k), e, tv[k].e);
      chk($sformatf("tv%0d_lat", k), lat, tv[k].lat);
      chk($sformatf("tv%0d_sp", k), bank[8], {4'h0, tv[k].nsp});
      chk($sformatf("tv%0d_rbw", k), rbw_n, tv[k].rbw);
      chk($sformatf("tv%0d_mw", k), mw_n, tv[k].mw);
      for (int i = 0; i < 8; i++) chk($sformatf("tv%0d_r%0d", k, i), bank[i], mr[i]);
    end
    // push then pop through the same slot
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    mr[3] = 16'hBEEF; mr[8] = 16'h0;
    poke_all();
    model_cmd(2'd0, 4'd3, me);
    run_cmd(2'd0, 4'd3, e, lat);
    chk("push_mem", mem[12'hFFF], 16'hBEEF);
    chk("push_sp", bank[8], 16'h0FFF);
    chk("push_lat_err", {lat[7:0], 6'(e)}, {8'd4, 6'd0});
    model_cmd(2'd1, 4'd5, me);
    run_cmd(2'd1, 4'd5, e, lat);
    chk("pop_r5", bank[5], 16'hBEEF);
    chk("pop_sp", bank[8], 16'h0000);
    chk("pop_lat_err", {lat[7:0], 6'(e)}, {8'd5, 6'd0});
    // save all, clobber, restore all
    for (int i = 0; i < 8; i++) mr[i] = 16'(i + 1);
    mr[8] = 16'h0;
    poke_all();
    model_cmd(2'd2, 4'd0, me);
    run_cmd(2'd2, 4'd0, e, lat);
    for (int i = 0; i < 8; i++) chk($sformatf("save_mem%0d", i), mem[12'hFFF - 12'(i)], 16'(i + 1));
    chk("save_sp", bank[8], 16'h0FF8);
    for (int i = 0; i < 8; i++) mr[i] = 16'hDEAD;
    poke_all();
    model_cmd(2'd3, 4'd0, me);
    run_cmd(2'd3, 4'd0, e, lat);
    for (int i = 0; i < 8; i++) chk($sformatf("restore_r%0d", i), bank[i], 16'(i + 1));
    chk("restore_sp", bank[8], 16'h0000);
    chk("restore_lat", lat, 19);
    // reset during the third save transfer
    for (int i = 0; i < 8; i++) mr[i] = 16'hA0 + 16'(i);
    mr[8] = 16'h0;
    poke_all();
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'd2; cmd_reg = 0; cnt_clr = 1;
    @(posedge clk);
    #1 cmd_valid = 0; cnt_clr = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_c%0d", c), done, 0);
    end
    rst = 1;
    @(negedge clk);
    chk("abort_idle", {cmd_ready, busy, done}, 3'b100);
    chk("abort_sp_kept", bank[8], 16'h0000);
    chk("abort_no_rbw", rbw_n, 0);
    chk("abort_partial_mem", {mem[12'hFFF], mem[12'hFFE]}, {16'hA0, 16'hA1});
    rst = 0;
    mm[12'hFFF] = 16'hA0; mm[12'hFFE] = 16'hA1;
    // random commands against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 8; i++) mr[i] = 16'($urandom);
        mr[8] = {4'h0, $urandom_range(0, 1) == 1 ? sp_pick[$urandom_range(0, 8)] : 12'hF00 | 12'($urandom_range(0, 255))};
        poke_all();
      end
      begin
        logic [1:0] op; logic [3:0] r;
        op = 2'($urandom);
        r = $urandom_range(0, 7) == 0 ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
        model_cmd(op, r, me);
        run_cmd(op, r, e, lat);
        chk($sformatf("rnd%0d_err", n), e, me);
        chk($sformatf("rnd%0d_lat", n), lat, exp_lat(op, me));
        for (int i = 0; i < 9; i++) chk($sformatf("rnd%0d_bank%0d", n, i), bank[i], mr[i]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
